// File: rtl/dsp_wb_master_pkg.sv
// Shared definitions for the DSP Wishbone master: FSM states, classic-cycle
// bus constants and err_flags bit positions.
package dsp_wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RETRY,
        ST_HOLD
    } wb_state_t;

    // Classic single-transfer cycles only
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // err_flags bit positions
    localparam int unsigned F_WB_ERR_BUS     = 0;
    localparam int unsigned F_WB_ERR_RETRY   = 1;
    localparam int unsigned F_WB_ERR_TIMEOUT = 2;

    // One-hot mask for a single err_flags bit
    function automatic logic [2:0] err_bit(input int unsigned idx);
        logic [2:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/dsp_wb_master.sv
// Single-transfer Wishbone B3 classic master for the DSP file-access engine.
// Converts a start/active request into one Wishbone cycle with retry,
// sticky error reporting and an optional bus watchdog.
// Optional feature: define DSP_WB_MASTER_TIMEOUT_EN to enable the watchdog.
module dsp_wb_master
    import dsp_wb_master_pkg::*;
#(
    parameter int unsigned dw        = 32,
    parameter int unsigned aw        = 32,
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          start,
    input  logic [aw-1:0] address,
    input  logic [3:0]    selection,
    input  logic          write,
    input  logic [dw-1:0] data_wr,
    output logic [dw-1:0] data_rd,
    output logic          active,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic          err_clr,
    output logic [2:0]    err_flags
);

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    // A zero watchdog limit would abort every transfer on its first cycle
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dsp_wb_master: TIMEOUT must be at least 1");
    end

    wb_state_t     state, state_nxt;
    logic [RW-1:0] retry_cnt;
    logic          load_rd;
    logic          clr_rd;
    logic          retry_inc;
    logic [2:0]    flag_set;
    logic          tmo_hit;
    logic          accept;

    assign accept = (state == ST_IDLE) && start;

`ifdef DSP_WB_MASTER_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;

    // Watchdog: counts cycles spent in BUS; any other state (including
    // RETRY) rearms it so every re-issue gets a full window.
    always_ff @(posedge wb_clk) begin
        if (wb_rst || state != ST_BUS) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Abort on the TIMEOUT-th silent BUS cycle
    always_comb begin
        tmo_hit = (state == ST_BUS) && (tmo_cnt == TMO_LIMIT);
    end
`else
    // Without the watchdog BUS waits indefinitely
    always_comb begin
        tmo_hit = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle datapath controls; bus responses use err > ack > rty
    always_comb begin
        logic done;
        state_nxt = state;
        done      = 1'b0;
        load_rd   = 1'b0;
        clr_rd    = 1'b0;
        retry_inc = 1'b0;
        flag_set  = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_err_i) begin
                    done     = 1'b1;
                    clr_rd   = 1'b1;
                    flag_set = err_bit(F_WB_ERR_BUS);
                end else if (wb_ack_i) begin
                    done    = 1'b1;
                    load_rd = !wb_we_o;
                end else if (wb_rty_i) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        done     = 1'b1;
                        clr_rd   = 1'b1;
                        flag_set = err_bit(F_WB_ERR_RETRY);
                    end else begin
                        state_nxt = ST_RETRY;
                    end
                end else if (tmo_hit) begin
                    done     = 1'b1;
                    clr_rd   = 1'b1;
                    flag_set = err_bit(F_WB_ERR_TIMEOUT);
                end
                // A start still held at completion parks in HOLD so it
                // cannot launch a second transfer.
                if (done) begin
                    state_nxt = start ? ST_HOLD : ST_IDLE;
                end
            end
            ST_RETRY: begin
                state_nxt = ST_BUS;
                retry_inc = 1'b1;
            end
            ST_HOLD: begin
                if (!start) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, read data, retry counter and sticky error flags
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            data_rd   <= '0;
            retry_cnt <= '0;
            err_flags <= '0;
        end else begin
            if (accept) begin
                wb_adr_o  <= address;
                wb_dat_o  <= data_wr;
                wb_sel_o  <= selection;
                wb_we_o   <= write;
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (load_rd) begin
                data_rd <= wb_dat_i;
            end else if (clr_rd) begin
                data_rd <= '0;
            end
            // A new error in the same cycle as err_clr survives the clear
            err_flags <= (err_flags & ~{3{err_clr}}) | flag_set;
        end
    end

    // Bus strobes decode straight from state so a reset drops them at once
    always_comb begin
        wb_cyc_o = (state == ST_BUS);
        wb_stb_o = (state == ST_BUS);
        active   = (state == ST_BUS) || (state == ST_RETRY);
        wb_cti_o = CTI_CLASSIC;
        wb_bte_o = BTE_LINEAR;
    end

endmodule
